// File: rtl/flag_pkg.sv
// ============================================================================
//  flag_pkg : shared types and screen constants for the goal-flag sprite.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package flag_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        WAVE  = 2'd0,
        LOWER = 2'd1,
        DOWN  = 2'd2,
        RAISE = 2'd3
    } flag_state_t;

endpackage

`default_nettype wire

// File: rtl/flag_anim_ctr.sv
// ============================================================================
//  flag_anim_ctr : sprite animation frame sequencer (hold counter + frame index).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module flag_anim_ctr #(
    parameter  int NUM_FRAMES = 4,
    parameter  int FRAME_HOLD = 8,
    localparam int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               enable,
    input  logic               clear,
    output logic [FRAME_W-1:0] frame
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(NUM_FRAMES - 1);

    logic [HOLD_W-1:0]  hold_q,  hold_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    // clear has priority so a sprite can be parked on frame 0 while disabled
    always_comb begin
        hold_d  = hold_q;
        frame_d = frame_q;
        if (clear) begin
            hold_d  = '0;
            frame_d = '0;
        end else if (enable) begin
            if (hold_q == HOLD_MAX) begin
                hold_d  = '0;
                frame_d = (frame_q == FRAME_MAX) ? '0 : frame_q + 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            hold_q  <= '0;
            frame_q <= '0;
        end else begin
            hold_q  <= hold_d;
            frame_q <= frame_d;
        end
    end

    assign frame = frame_q;

endmodule

`default_nettype wire

// File: rtl/capture_flag.sv
// ============================================================================
//  capture_flag : waving goal flag that lowers on capture and rises on respawn.
//  Optional macro CAPTURE_FLAG_BOB_EN adds a 1-pixel bob while waving.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module capture_flag
    import flag_pkg::*;
#(
    parameter  int X_POS      = 575,
    parameter  int Y_TOP      = 245,
    parameter  int Y_BOT      = 365,
    parameter  int STEP       = 4,
    parameter  int SIZE       = 32,
    parameter  int WIDTH      = 44,
    parameter  int HEIGHT     = 40,
    parameter  int NUM_FRAMES = 4,
    parameter  int FRAME_HOLD = 8,
    localparam int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               capture,
    input  logic               respawn,
    output logic [COORD_W-1:0] FlagX,
    output logic [COORD_W-1:0] FlagY,
    output logic [COORD_W-1:0] FlagS,
    output logic [COORD_W-1:0] FlagWidth,
    output logic [COORD_W-1:0] FlagHeight,
    output logic [FRAME_W-1:0] FlagFrame,
    output logic               FlagDown,
    output logic               FlagCaptured,
    output logic [7:0]         CaptureCount
);

    localparam coord_t        Y_TOP_C     = coord_t'(Y_TOP);
    localparam coord_t        Y_BOT_C     = coord_t'(Y_BOT);
    localparam coord_t        STEP_C      = coord_t'(STEP);
    localparam logic [10:0]   STEP_X      = 11'(STEP);
    localparam logic [10:0]   Y_BOT_X     = 11'(Y_BOT);
    localparam logic [10:0]   RAISE_LIMIT = 11'(Y_TOP + STEP);

    flag_state_t state_q, state_d;
    coord_t      y_q, y_d;
    logic        down_q, down_d;
    logic        captured_q, captured_d;
    logic [7:0]  count_q, count_d;
    logic [10:0] y_ext, lower_sum;
    logic        anim_en, anim_clr;

    // Extra bit keeps the descent compare honest near the top of the range
    always_comb begin
        y_ext      = {1'b0, y_q};
        lower_sum  = y_ext + STEP_X;
        state_d    = state_q;
        y_d        = y_q;
        count_d    = count_q;
        captured_d = 1'b0;
        unique case (state_q)
            WAVE: begin
                if (capture) state_d = LOWER;
            end
            LOWER: begin
                if (lower_sum >= Y_BOT_X) begin
                    y_d        = Y_BOT_C;
                    state_d    = DOWN;
                    captured_d = 1'b1;
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                end else begin
                    y_d = lower_sum[COORD_W-1:0];
                end
            end
            DOWN: begin
                y_d = Y_BOT_C;
                if (respawn) state_d = RAISE;
            end
            RAISE: begin
                if (y_ext <= RAISE_LIMIT) begin
                    y_d     = Y_TOP_C;
                    state_d = WAVE;
                end else begin
                    y_d = y_q - STEP_C;
                end
            end
            default: state_d = WAVE;
        endcase
        down_d   = (state_d == DOWN);
        anim_en  = (state_q == WAVE);
        anim_clr = (state_q == DOWN) || (state_q == RAISE) || (state_d == DOWN);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= WAVE;
            y_q        <= Y_TOP_C;
            down_q     <= 1'b0;
            captured_q <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            down_q     <= down_d;
            captured_q <= captured_d;
            count_q    <= count_d;
        end
    end

    flag_anim_ctr #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD)
    ) u_anim (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .enable    (anim_en),
        .clear     (anim_clr),
        .frame     (FlagFrame)
    );

`ifdef CAPTURE_FLAG_BOB_EN
    assign FlagY = y_q + {{(COORD_W-1){1'b0}}, (state_q == WAVE) & FlagFrame[0]};
`else
    assign FlagY = y_q;
`endif

    assign FlagX        = coord_t'(X_POS);
    assign FlagS        = coord_t'(SIZE);
    assign FlagWidth    = coord_t'(WIDTH);
    assign FlagHeight   = coord_t'(HEIGHT);
    assign FlagDown     = down_q;
    assign FlagCaptured = captured_q;
    assign CaptureCount = count_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_flag.sv
// ============================================================================
//  tb_capture_flag : vector table, corner sequences and random run vs. model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_capture_flag;

    localparam int Y_TOP = 245, Y_BOT = 365, STEP = 4;
    localparam int NUM_FRAMES = 4, FRAME_HOLD = 8;
    localparam int M_WAVE = 0, M_LOWER = 1, M_DOWN = 2, M_RAISE = 3;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1, capture = 1'b0, respawn = 1'b0;
    logic       cap2 = 1'b0, resp2 = 1'b0;
    logic [9:0] FlagX, FlagY, FlagS, FlagWidth, FlagHeight;
    logic [1:0] FlagFrame;
    logic       FlagDown, FlagCaptured;
    logic [7:0] CaptureCount;
    logic [9:0] X2, Y2, S2, W2, H2;
    logic [0:0] Frame2;
    logic       Down2, Capt2;
    logic [7:0] Cnt2;

    capture_flag dut (
        .frame_clk(frame_clk), .Reset(Reset), .capture(capture), .respawn(respawn),
        .FlagX(FlagX), .FlagY(FlagY), .FlagS(FlagS), .FlagWidth(FlagWidth),
        .FlagHeight(FlagHeight), .FlagFrame(FlagFrame), .FlagDown(FlagDown),
        .FlagCaptured(FlagCaptured), .CaptureCount(CaptureCount)
    );

    // Degenerate pole: top == bottom, single static frame
    capture_flag #(.Y_TOP(100), .Y_BOT(100), .NUM_FRAMES(1), .FRAME_HOLD(1)) dut2 (
        .frame_clk(frame_clk), .Reset(Reset), .capture(cap2), .respawn(resp2),
        .FlagX(X2), .FlagY(Y2), .FlagS(S2), .FlagWidth(W2),
        .FlagHeight(H2), .FlagFrame(Frame2), .FlagDown(Down2),
        .FlagCaptured(Capt2), .CaptureCount(Cnt2)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0, n_fail = 0;
    int m_mode, m_y, m_ticks, m_steps, m_cnt, m_capt;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bob_of(input bit waving, input int frame);
        int b = 0;
`ifdef CAPTURE_FLAG_BOB_EN
        if (waving && (frame % 2 == 1)) b = 1;
`endif
        return b;
    endfunction

    task automatic model_reset();
        m_mode = M_WAVE; m_y = Y_TOP; m_ticks = 0; m_steps = 0; m_cnt = 0; m_capt = 0;
    endtask

    // Position from step count, frame from time spent waving
    task automatic model_edge(input bit cap, input bit resp);
        m_capt = 0;
        case (m_mode)
            M_WAVE: begin
                m_ticks++;
                if (cap) begin m_mode = M_LOWER; m_steps = 0; end
            end
            M_LOWER: begin
                m_steps++;
                if (Y_TOP + STEP * m_steps >= Y_BOT) begin
                    m_y = Y_BOT; m_mode = M_DOWN; m_capt = 1;
                    if (m_cnt < 255) m_cnt++;
                end else m_y = Y_TOP + STEP * m_steps;
            end
            M_DOWN: if (resp) begin m_mode = M_RAISE; m_steps = 0; end
            default: begin
                m_steps++;
                if (Y_BOT - STEP * m_steps <= Y_TOP) begin
                    m_y = Y_TOP; m_mode = M_WAVE; m_ticks = 0;
                end else m_y = Y_BOT - STEP * m_steps;
            end
        endcase
    endtask

    function automatic int model_frame();
        if (m_mode == M_WAVE || m_mode == M_LOWER) return (m_ticks / FRAME_HOLD) % NUM_FRAMES;
        return 0;
    endfunction

    task automatic check_model();
        chk("model_y", int'(FlagY), m_y + bob_of(m_mode == M_WAVE, model_frame()));
        chk("model_frame", int'(FlagFrame), model_frame());
        chk("model_down", int'(FlagDown), (m_mode == M_DOWN) ? 1 : 0);
        chk("model_captured", int'(FlagCaptured), m_capt);
        chk("model_count", int'(CaptureCount), m_cnt);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        if (!Reset) model_edge(capture, respawn);
        #1;
        check_model();
    endtask

    task automatic async_reset();
        #2 Reset = 1'b1;
        model_reset();
        #1;
        check_model();
        chk("async_rst_y", int'(FlagY), Y_TOP);
        @(posedge frame_clk);
        #1 Reset = 1'b0;
    endtask

    typedef struct {
        bit cap; bit resp; int cycles;
        int y; int frame; bit down; bit capt; int cnt; bit wave;
    } vec_t;
    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0, 0,  7, 245, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 0,  1, 245, 1, 0, 0, 0, 1};
        vecs[2]  = '{0, 0,  8, 245, 2, 0, 0, 0, 1};
        vecs[3]  = '{0, 0, 16, 245, 0, 0, 0, 0, 1};
        vecs[4]  = '{0, 0, 13, 245, 1, 0, 0, 0, 1};
        vecs[5]  = '{1, 1,  1, 245, 1, 0, 0, 0, 0};
        vecs[6]  = '{0, 0,  1, 249, 1, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 28, 361, 1, 0, 0, 0, 0};
        vecs[8]  = '{0, 0,  1, 365, 0, 1, 1, 1, 0};
        vecs[9]  = '{1, 0,  3, 365, 0, 1, 0, 1, 0};
        vecs[10] = '{0, 1,  1, 365, 0, 0, 0, 1, 0};
        vecs[11] = '{0, 0, 29, 249, 0, 0, 0, 1, 0};
        vecs[12] = '{0, 0,  1, 245, 0, 0, 0, 1, 1};
        vecs[13] = '{0, 0,  8, 245, 1, 0, 0, 1, 1};

        model_reset();
        repeat (2) @(posedge frame_clk);
        #1 Reset = 1'b0;
        chk("rst_x", int'(FlagX), 575);
        chk("rst_y", int'(FlagY), 245);
        chk("rst_s", int'(FlagS), 32);
        chk("rst_w", int'(FlagWidth), 44);
        chk("rst_h", int'(FlagHeight), 40);
        chk("rst_frame", int'(FlagFrame), 0);
        chk("rst_down", int'(FlagDown), 0);
        chk("rst_count", int'(CaptureCount), 0);

        foreach (vecs[i]) begin
            capture = vecs[i].cap;
            respawn = vecs[i].resp;
            repeat (vecs[i].cycles) tick();
            chk($sformatf("vec%0d_y", i), int'(FlagY), vecs[i].y + bob_of(vecs[i].wave, vecs[i].frame));
            chk($sformatf("vec%0d_frame", i), int'(FlagFrame), vecs[i].frame);
            chk($sformatf("vec%0d_down", i), int'(FlagDown), int'(vecs[i].down));
            chk($sformatf("vec%0d_capt", i), int'(FlagCaptured), int'(vecs[i].capt));
            chk($sformatf("vec%0d_cnt", i), int'(CaptureCount), vecs[i].cnt);
        end
        capture = 1'b0; respawn = 1'b0;

        // Asynchronous reset mid-descent
        capture = 1'b1; tick(); capture = 1'b0;
        repeat (14) tick();
        chk("mid_lower_y", int'(FlagY), 301);
        async_reset();
        chk("async_rst_cnt", int'(CaptureCount), 0);
        chk("async_rst_frame", int'(FlagFrame), 0);

        // Degenerate pole: one-edge lower and raise, priority rules
        cap2 = 1'b1; tick(); cap2 = 1'b0;
        chk("deg_lower_down", int'(Down2), 0);
        tick();
        chk("deg_down_y", int'(Y2), 100);
        chk("deg_down", int'(Down2), 1);
        chk("deg_capt", int'(Capt2), 1);
        chk("deg_cnt1", int'(Cnt2), 1);
        tick();
        chk("deg_capt_clr", int'(Capt2), 0);
        resp2 = 1'b1; tick(); resp2 = 1'b0;
        chk("deg_raise_down", int'(Down2), 0);
        tick();
        chk("deg_wave_y", int'(Y2), 100);
        cap2 = 1'b1; resp2 = 1'b1; tick(); cap2 = 1'b0; resp2 = 1'b0;
        chk("deg_both_wave", int'(Down2), 0);
        tick();
        chk("deg_both_wave_down", int'(Down2), 1);
        chk("deg_cnt2", int'(Cnt2), 2);
        cap2 = 1'b1; resp2 = 1'b1; tick(); cap2 = 1'b0; resp2 = 1'b0;
        chk("deg_both_down", int'(Down2), 0);
        chk("deg_frame", int'(Frame2), 0);

        // Random run against the model
        for (int n = 0; n < 3000; n++) begin
            capture = ($urandom_range(0, 9) == 0);
            respawn = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 599) == 0) async_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
